// File: rtl/frodo_decode_pack.sv
// frodo_decode_pack
// Round-mods a stream of coefficient words down to B bits each and packs a block
// of NCOEF results LSB-first into OUT_W-bit output words. B comes from the
// sec_lvl value captured on the first beat of each block. Two banks ping-pong:
// one bank fills while the other drains.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   clr        synchronous clear: drops partial block and both banks
//   sec_lvl    level select (00: B=2/LOGQ=15, 01: B=3/LOGQ=16, 10: B=4/LOGQ=16, 11: illegal)
//   in_data    LANES coefficients, lane i at [i*COEF_W +: COEF_W]
//   in_valid   in_data valid
//   in_ready   a beat can be accepted
//   out_data   packed output word, 0 while out_valid is low
//   out_valid  out_data valid
//   out_ready  downstream accepts a word
//   out_last   marks the final word of a block
//   err_lvl    one-cycle pulse after a block starts with sec_lvl = 11
module frodo_decode_pack #(
  parameter int COEF_W = 16,
  parameter int LANES  = 4,
  parameter int NCOEF  = 64,
  parameter int OUT_W  = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic [1:0]                sec_lvl,
  input  logic [LANES*COEF_W-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      err_lvl
);

  localparam int BEATS = NCOEF / LANES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Each coefficient slot is stored 4 bits wide (widest B); packing to the
  // block's actual B happens on the read side.
  localparam int PW    = NCOEF * 4;
  localparam int MAXW  = PW / OUT_W;
  localparam int WCW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_st_t;

  // r = ((c + 2^(LOGQ-B-1)) >> (LOGQ-B)) mod 2^B, bits of c at or above LOGQ dropped.
  function automatic logic [3:0] roundmod(input logic [COEF_W-1:0] c,
                                          input logic [1:0]        lvl);
    logic [COEF_W:0] cm;
    logic [COEF_W:0] sum;
    int b;
    int logq;
    b    = int'(lvl) + 2;
    logq = (lvl == 2'b00) ? 15 : 16;
    cm   = {1'b0, c};
    for (int i = 0; i <= COEF_W; i++) begin
      if (i >= logq) cm[i] = 1'b0;
    end
    sum = cm + ((COEF_W+1)'(1) << (logq - b - 1));
    sum = sum >> (logq - b);
    case (lvl)
      2'b00:   return {2'b00, sum[1:0]};
      2'b01:   return {1'b0, sum[2:0]};
      2'b10:   return sum[3:0];
      default: return 4'd0;
    endcase
  endfunction

  // Index of the final output word of a block at the given level.
  function automatic logic [WCW-1:0] last_word(input logic [1:0] lvl);
    case (lvl)
      2'b00:   return WCW'(2 * NCOEF / OUT_W - 1);
      2'b01:   return WCW'(3 * NCOEF / OUT_W - 1);
      2'b10:   return WCW'(4 * NCOEF / OUT_W - 1);
      default: return '0;
    endcase
  endfunction

  bank_st_t       st [2];
  logic [1:0]     lvl [2];
  logic           wr_bank;
  logic           rd_bank;
  logic [BCW-1:0] beat_cnt;
  logic [WCW-1:0] word_cnt;
  logic           up;
  logic [3:0]     slot [2][NCOEF];

  logic           in_fire;
  logic           out_fire;
  logic           last_beat;
  logic [1:0]     cur_lvl;
  logic [1:0]     rd_lvl;
  logic [PW-1:0]  pack_vec;

  // The first beat of a block uses the live sec_lvl; later beats use the latched one.
  assign cur_lvl   = (beat_cnt == '0) ? sec_lvl : lvl[wr_bank];
  assign in_ready  = up && (st[wr_bank] == EMPTY || st[wr_bank] == FILLING);
  assign in_fire   = in_valid && in_ready;
  assign last_beat = (beat_cnt == BCW'(BEATS - 1));

  assign rd_lvl    = lvl[rd_bank];
  assign out_valid = (st[rd_bank] == FULL || st[rd_bank] == DRAINING);
  assign out_last  = out_valid && (word_cnt == last_word(rd_lvl));
  assign out_fire  = out_valid && out_ready;

  // Control: bank states, pointers, counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up       <= 1'b0;
      st[0]    <= EMPTY;
      st[1]    <= EMPTY;
      lvl[0]   <= 2'b00;
      lvl[1]   <= 2'b00;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      beat_cnt <= '0;
      word_cnt <= '0;
      err_lvl  <= 1'b0;
    end else begin
      up      <= 1'b1;
      err_lvl <= 1'b0;
      if (clr) begin
        st[0]    <= EMPTY;
        st[1]    <= EMPTY;
        wr_bank  <= 1'b0;
        rd_bank  <= 1'b0;
        beat_cnt <= '0;
        word_cnt <= '0;
      end else begin
        if (in_fire) begin
          if (beat_cnt == '0) begin
            lvl[wr_bank] <= sec_lvl;
            err_lvl      <= (sec_lvl == 2'b11);
          end
          if (last_beat) begin
            beat_cnt <= '0;
            // An illegal block is released in place; the write pointer stays
            // so that it keeps tracking the read pointer's bank order.
            if (cur_lvl == 2'b11) begin
              st[wr_bank] <= EMPTY;
            end else begin
              st[wr_bank] <= FULL;
              wr_bank     <= ~wr_bank;
            end
          end else begin
            beat_cnt    <= beat_cnt + 1'b1;
            st[wr_bank] <= FILLING;
          end
        end
        // The read bank is FULL/DRAINING and the write bank EMPTY/FILLING, so
        // both updates never target the same bank in one cycle.
        if (out_fire) begin
          if (out_last) begin
            st[rd_bank] <= EMPTY;
            rd_bank     <= ~rd_bank;
            word_cnt    <= '0;
          end else begin
            st[rd_bank] <= DRAINING;
            word_cnt    <= word_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Datapath: round-mod each lane into its slot of the bank being filled.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int i = 0; i < LANES; i++) begin
        slot[wr_bank][int'(beat_cnt) * LANES + i] <= roundmod(in_data[i*COEF_W +: COEF_W], cur_lvl);
      end
    end
  end

  // Read side: pack the read bank's slots at its B and select the current word.
  always_comb begin
    pack_vec = '0;
    for (int k = 0; k < NCOEF; k++) begin
      case (rd_lvl)
        2'b00:   pack_vec[k*2 +: 2] = slot[rd_bank][k][1:0];
        2'b01:   pack_vec[k*3 +: 3] = slot[rd_bank][k][2:0];
        2'b10:   pack_vec[k*4 +: 4] = slot[rd_bank][k];
        default: ;
      endcase
    end
    out_data = out_valid ? pack_vec[int'(word_cnt) * OUT_W +: OUT_W] : '0;
  end

endmodule

// File: tb/tb_frodo_decode_pack.sv
module tb_frodo_decode_pack;
  localparam int COEF_W = 16;
  localparam int LANES  = 4;
  localparam int NCOEF  = 64;
  localparam int OUT_W  = 64;
  localparam int BEATS  = NCOEF / LANES;
  localparam int CFW    = NCOEF * COEF_W;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              clr = 1'b0;
  logic [1:0]        sec_lvl = 2'b00;
  logic [LANES*COEF_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              err_lvl;

  int n_pass = 0;
  int n_chk  = 0;
  int rdy_mode = 1;
  int stalls = 0;

  always #5 clk = ~clk;

  frodo_decode_pack #(.COEF_W(COEF_W), .LANES(LANES), .NCOEF(NCOEF), .OUT_W(OUT_W)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .sec_lvl(sec_lvl),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .err_lvl(err_lvl)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain arithmetic round-mod and bit packing of a whole block.
  function automatic logic [255:0] model_pack(input logic [CFW-1:0] cf, input int lvl);
    logic [255:0] p;
    int b, logq, c, r;
    p = '0;
    b = lvl + 2;
    logq = (lvl == 0) ? 15 : 16;
    for (int k = 0; k < NCOEF; k++) begin
      c = int'(cf[k*COEF_W +: COEF_W]) & ((1 << logq) - 1);
      r = ((c + (1 << (logq - b - 1))) >> (logq - b)) % (1 << b);
      p = p | (256'(r) << (k * b));
    end
    return p;
  endfunction

  function automatic logic [CFW-1:0] make_cf(input int mode, input int sh, input logic [15:0] val);
    logic [CFW-1:0] cf;
    for (int k = 0; k < NCOEF; k++) begin
      case (mode)
        0:       cf[k*COEF_W +: COEF_W] = val;
        1:       cf[k*COEF_W +: COEF_W] = 16'(k << sh);
        default: cf[k*COEF_W +: COEF_W] = 16'($urandom);
      endcase
    end
    return cf;
  endfunction

  typedef struct {
    logic [63:0] d;
    logic        last;
  } word_t;
  word_t q[$];

  // Per-cycle compare against the model; model state advances on predicted transfers.
  logic [CFW-1:0] mcf;
  int  mbeat = 0;
  int  mlvl  = 0;
  bit  up_m  = 0;
  bit  err_exp = 0;
  initial begin
    int nblk;
    logic [255:0] p;
    int nw;
    word_t w;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        q.delete(); mbeat = 0; up_m = 0; err_exp = 0;
      end
      nblk = 0;
      foreach (q[i]) if (q[i].last) nblk++;
      check("in_ready", 64'(in_ready), 64'(up_m && nblk < 2));
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("out_data", out_data, q[0].d);
        check("out_last", 64'(out_last), 64'(q[0].last));
      end else begin
        check("out_data_idle", out_data, 64'd0);
        check("out_last_idle", 64'(out_last), 64'd0);
      end
      check("err_lvl", 64'(err_lvl), 64'(err_exp));
      err_exp = 0;
      if (rstn && !clr) begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && up_m && nblk < 2) begin
          if (mbeat == 0) begin
            mlvl = int'(sec_lvl);
            err_exp = (sec_lvl == 2'b11);
          end
          mcf[mbeat*LANES*COEF_W +: LANES*COEF_W] = in_data;
          mbeat++;
          if (mbeat == BEATS) begin
            mbeat = 0;
            if (mlvl != 3) begin
              p = model_pack(mcf, mlvl);
              nw = NCOEF * (mlvl + 2) / OUT_W;
              for (int j = 0; j < nw; j++) begin
                w.d = p[j*OUT_W +: OUT_W];
                w.last = (j == nw - 1);
                q.push_back(w);
              end
            end
          end
        end
      end else if (clr) begin
        q.delete(); mbeat = 0;
      end
      up_m = rstn;
    end
  end

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom);
    endcase
  end

  // Callers are aligned just after a rising edge.
  task automatic send_block(input logic [CFW-1:0] cf, input int lvl, input int nbeats,
                            input int vprob, input bit toggle);
    int bt, waits;
    bit fire;
    bt = 0; waits = 0;
    while (bt < nbeats) begin
      in_valid = ($urandom_range(99) < vprob);
      in_data  = cf[bt*LANES*COEF_W +: LANES*COEF_W];
      sec_lvl  = (toggle && bt > 0) ? 2'($urandom) : 2'(lvl);
      @(negedge clk);
      fire = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      @(posedge clk); #1;
      if (fire) bt++;
      else if (++waits > 2000) begin
        n_chk++;
        $display("FAIL send_timeout: got beat %0d required %0d", bt, nbeats);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d words pending required 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] p;
    int st0;
    // Pin the reference model with hand-computed values.
    p = model_pack(make_cf(0, 0, 16'h4000), 0);
    check("pin_l0_w0", p[63:0], 64'hAAAAAAAAAAAAAAAA);
    check("pin_l0_w1", p[127:64], 64'hAAAAAAAAAAAAAAAA);
    p = model_pack(make_cf(0, 0, 16'h1234), 2);
    check("pin_l2_w3", p[255:192], 64'h1111111111111111);
    p = model_pack(make_cf(0, 0, 16'hFFFF), 1);
    check("pin_l1_wrap", p[191:0] == '0 ? 64'd0 : 64'd1, 64'd0);
    p = model_pack(make_cf(1, 12, 16'h0), 2);
    check("pin_ramp_l2", p[63:0], 64'hFEDCBA9876543210);
    p = model_pack(make_cf(1, 13, 16'h0), 0);
    check("pin_ramp_l0", p[63:0], 64'hE4E4E4E4E4E4E4E4);
    p = model_pack(make_cf(1, 13, 16'h0), 1);
    check("pin_ramp_l1", 64'(p[23:0]), 64'hFAC688);

    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed blocks.
    send_block(make_cf(0, 0, 16'h4000), 0, BEATS, 100, 0); wait_idle();
    send_block(make_cf(0, 0, 16'h1234), 2, BEATS, 100, 0); wait_idle();
    send_block(make_cf(0, 0, 16'hFFFF), 1, BEATS, 100, 0); wait_idle();
    send_block(make_cf(1, 13, 16'h0), 0, BEATS, 100, 0); wait_idle();
    send_block(make_cf(1, 13, 16'h0), 1, BEATS, 100, 0); wait_idle();
    send_block(make_cf(1, 12, 16'h0), 2, BEATS, 100, 0); wait_idle();

    // Back-to-back with ready held high: input never stalls.
    stalls = 0;
    send_block(make_cf(2, 0, 16'h0), 0, BEATS, 100, 0);
    send_block(make_cf(2, 0, 16'h0), 1, BEATS, 100, 0);
    send_block(make_cf(2, 0, 16'h0), 2, BEATS, 100, 0);
    send_block(make_cf(2, 0, 16'h0), 0, BEATS, 100, 0);
    check("b2b_stalls", 64'(stalls), 64'd0);
    wait_idle();

    // Backpressure: third block must stall until the output side releases.
    rdy_mode = 0;
    @(posedge clk); #1;
    stalls = 0;
    fork
      begin
        send_block(make_cf(2, 0, 16'h0), 0, BEATS, 100, 0);
        send_block(make_cf(2, 0, 16'h0), 2, BEATS, 100, 0);
        send_block(make_cf(2, 0, 16'h0), 1, BEATS, 100, 0);
      end
      begin
        repeat (60) @(posedge clk);
        #1;
        st0 = stalls;
        rdy_mode = 1;
      end
    join
    check("bp_stalled", 64'(st0 > 0), 64'd1);
    wait_idle();

    // Illegal level, then normal block, then mid-block level toggling.
    send_block(make_cf(2, 0, 16'h0), 3, BEATS, 100, 0);
    send_block(make_cf(2, 0, 16'h0), 0, BEATS, 100, 0);
    send_block(make_cf(2, 0, 16'h0), 1, BEATS, 100, 1);
    wait_idle();

    // clr after 8 beats.
    send_block(make_cf(2, 0, 16'h0), 2, 8, 100, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    send_block(make_cf(2, 0, 16'h0), 0, BEATS, 100, 0);
    wait_idle();

    // Reset after 5 beats.
    send_block(make_cf(2, 0, 16'h0), 1, 5, 100, 0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    send_block(make_cf(2, 0, 16'h0), 2, BEATS, 100, 0);
    wait_idle();

    // Randomized traffic on both sides.
    rdy_mode = 2;
    for (int n = 0; n < 20; n++) begin
      send_block(make_cf(2, 0, 16'h0), ($urandom_range(9) == 0) ? 3 : $urandom_range(2),
                 BEATS, 70, 1'($urandom));
    end
    rdy_mode = 1;
    wait_idle();
    check("final_drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
